// File: rtl/ahb_split_slave.sv
// ---------------------------------------------------------------------------
// ahb_split_slave
//
// AHB slave for the 1 KB SPLIT window. The first NONSEQ from a master gets a
// two-cycle SPLIT response. A per-master countdown then releases that master
// with a one-cycle HSPLIT pulse. Its retried NONSEQ, and any SEQ beats that
// follow, complete OKAY with zero wait states against an internal word memory.
//
// Handshake: an address phase is accepted on a rising edge where
// HSEL & HREADY are high and the response FSM is in a state that drives
// HREADYOUT=1 (OKAY_ST, ERR2, SPL2). The data phase ends on the first edge
// where HREADY is high again. Nothing is accepted while HREADYOUT is low.
//
// Ports
//   HCLK, HRESETn     clock, synchronous active-low reset
//   HSEL              slave select from the address decoder
//   HADDR, HTRANS, HWRITE, HSIZE, HMASTER, HMASTLOCK   address-phase controls
//   HWDATA            write data (data phase)
//   HREADY            bus-level ready from the response mux
//   HRDATA            read data (0 outside an OKAY read data phase)
//   HREADYOUT, HRESP  slave response
//   HSPLIT            one-cycle per-master release pulses
//   fsm_state         response FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module ahb_split_slave #(
    parameter int NUM_MASTERS = 4,
    parameter int SPLIT_DELAY = 8,
    parameter int MEM_WORDS   = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [3:0]  HMASTER,
    input  logic        HMASTLOCK,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [15:0] HSPLIT,
    output logic [2:0]  fsm_state
);
    localparam int CW = $clog2(SPLIT_DELAY + 1);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        OKAY_ST = 3'd0,
        ERR1    = 3'd1,
        ERR2    = 3'd2,
        SPL1    = 3'd3,
        SPL2    = 3'd4
    } state_t;

    state_t state, state_next, cls;

    logic                   accept_ok, acc, misaligned, data_ok, ent_hit, take_ent;
    logic [NUM_MASTERS-1:0] ent_clr, pending, entitled;
    logic [CW-1:0]          cnt [NUM_MASTERS];

    logic [9:0]  addr_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic [3:0]  master_q;
    logic        active_q;   // an OKAY NONSEQ/SEQ data phase is in progress

    logic [31:0]   mem [MEM_WORDS];
    logic [3:0]    be;
    logic          we;
    logic [AW-1:0] word_idx;

    // The decoder guarantees the window, so the upper address bits carry no information.
    logic unused_addr;
    assign unused_addr = ^HADDR[31:10];

    assign accept_ok = (state == OKAY_ST) || (state == ERR2) || (state == SPL2);
    assign acc       = HSEL & HREADY & accept_ok;
    assign fsm_state = state;

    // Transfer classification. The order of the checks sets the priority:
    // idle/busy, then size/alignment errors, then the OKAY cases, then split.
    always_comb begin
        ent_hit  = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (HMASTER == 4'(m)) ent_hit = entitled[m];
        end
        misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
        cls      = OKAY_ST;
        data_ok  = 1'b0;
        take_ent = 1'b0;
        if (!HTRANS[1]) begin
            cls = OKAY_ST;
        end else if ((HSIZE > 3'd2) || misaligned) begin
            cls = ERR1;
        end else if (HTRANS[0]) begin
            data_ok = 1'b1;
        end else if (HMASTLOCK) begin
            data_ok = 1'b1;
        end else if (ent_hit) begin
            data_ok  = 1'b1;
            take_ent = 1'b1;
        end else begin
            cls = SPL1;
        end
        ent_clr = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            ent_clr[m] = acc && take_ent && (HMASTER == 4'(m));
        end
    end

    // Response FSM: next state and outputs.
    always_comb begin
        state_next = OKAY_ST;
        HREADYOUT  = 1'b1;
        HRESP      = 2'b00;
        case (state)
            OKAY_ST: state_next = acc ? cls : OKAY_ST;
            ERR1: begin
                state_next = ERR2;
                HREADYOUT  = 1'b0;
                HRESP      = 2'b01;
            end
            ERR2: begin
                state_next = acc ? cls : OKAY_ST;
                HRESP      = 2'b01;
            end
            SPL1: begin
                state_next = SPL2;
                HREADYOUT  = 1'b0;
                HRESP      = 2'b11;
            end
            SPL2: begin
                state_next = acc ? cls : OKAY_ST;
                HRESP      = 2'b11;
            end
            default: state_next = OKAY_ST;
        endcase
    end

    // Release pulse fires in the cycle the countdown shows 1.
    always_comb begin
        HSPLIT = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            HSPLIT[m] = pending[m] && (cnt[m] == CW'(1));
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= OKAY_ST;
            active_q <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            master_q <= '0;
            pending  <= '0;
            entitled <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) cnt[m] <= '0;
        end else begin
            state    <= state_next;
            active_q <= acc & data_ok;
            if (acc) begin
                addr_q   <= HADDR[9:0];
                write_q  <= HWRITE;
                size_q   <= HSIZE;
                master_q <= HMASTER;
            end
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (ent_clr[m]) entitled[m] <= 1'b0;
                if (pending[m]) begin
                    // A repeat split of a pending master leaves its countdown alone.
                    cnt[m] <= cnt[m] - CW'(1);
                    if (cnt[m] == CW'(1)) begin
                        pending[m]  <= 1'b0;
                        entitled[m] <= 1'b1;
                    end
                end else if ((state == SPL2) && (master_q == 4'(m))) begin
                    pending[m] <= 1'b1;
                    cnt[m]     <= CW'(SPLIT_DELAY);
                end
            end
        end
    end

    // Little-endian byte lanes for the registered size/address.
    always_comb begin
        case (size_q)
            3'd0:    be = 4'b0001 << addr_q[1:0];
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign word_idx = addr_q[AW+1:2];
    assign we       = active_q & write_q & HREADY;
    assign HRDATA   = (active_q && !write_q) ? mem[word_idx] : 32'h0;

    // Storage is not reset; writes are suppressed while reset is held.
    always_ff @(posedge HCLK) begin
        if (HRESETn && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule
